heepsilon_ext_pwr_seq: RTL and testbench
========================================

Name: heepsilon_ext_pwr_seq

Overview:
Power/clock/reset sequencer for NUM_CH external accelerator subsystems (CGRA and successors) attached to the X-HEEP external-subsystem control pins.
- Each channel runs an independent FSM that turns a level on/off request into an ordered sequence: drain, isolate, reset, clock gate, power switch with ack.
- Raises per-channel completion and error events, plus one OR'ed interrupt line that feeds ext_intr_vector.

Parameters:
NUM_CH, 2, number of independently sequenced subsystems (1..8)
ISO_SETTLE, 4, cycles isolation is held before reset assert and after reset release (>=1)
RST_HOLD, 8, cycles channel reset is held with clock running (>=1)
ACK_TIMEOUT, 255, max cycles to wait for power-switch ack before error (>=1)
CNT_W, $clog2(max(ISO_SETTLE,RST_HOLD,ACK_TIMEOUT)+1), internal counter width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
off_req_i  in  NUM_CH  level; 1 = channel requested powered off
busy_i  in  NUM_CH  channel still has outstanding bus/compute activity
sw_ack_i  in  NUM_CH  power-switch ack; mirrors switch state; already synchronous to clk_i
err_clr_i  in  NUM_CH  1-cycle pulse; clears error and retries
clk_en_o  out  NUM_CH  channel clock enable
sw_on_o  out  NUM_CH  power switch closed
iso_o  out  NUM_CH  output isolation active
ch_rst_o  out  NUM_CH  channel logic reset, active-high
state_o  out  4*NUM_CH  per-channel FSM state encoding
on_o  out  NUM_CH  1 only in state ON
err_o  out  NUM_CH  sticky timeout error
evt_o  out  NUM_CH  1-cycle pulse on entering ON, OFF or ERR
intr_o  out  1  registered OR of evt_o

Behaviour:
- Reset: every channel goes to ON.
  - Reset outputs: clk_en=1, sw_on=1, iso=0, ch_rst=0, on=1, err=0, evt=0, intr=0.
  - rst_i mid-sequence forces ON immediately, whatever the current state.
- States and output tuple (clk_en, sw_on, iso, ch_rst):
  - ON (1,1,0,0)
  - DRAIN (1,1,0,0)
  - ISO (1,1,1,0)
  - RST (1,1,1,1)
  - SW_OFF (0,0,1,1)
  - OFF (0,0,1,1)
  - SW_ON (0,1,1,1)
  - CLK_ON (1,1,1,1)
  - DEISO (1,1,1,0)
  - ERR: holds the tuple of the state that timed out.
- Transitions:
  - ON -> DRAIN when off_req=1.
  - DRAIN -> ISO when busy=0. DRAIN -> ON if off_req drops; this is the only abort point.
  - ISO -> RST after ISO_SETTLE cycles.
  - RST -> SW_OFF after RST_HOLD cycles.
  - SW_OFF -> OFF when sw_ack=0.
  - OFF -> SW_ON when off_req=0.
  - SW_ON -> CLK_ON when sw_ack=1.
  - CLK_ON -> DEISO after RST_HOLD cycles.
  - DEISO -> ON after ISO_SETTLE cycles.
- Mid-sequence requests: once in ISO/RST/SW_OFF, the power-down completes to OFF even if off_req drops. Once in SW_ON/CLK_ON/DEISO, the power-up completes to ON even if off_req rises; the next transition is then taken from ON/OFF.
- Counters: a "N cycles" state is occupied exactly N cycles, with the counter loaded on entry and decremented to 0.
- Timeout: in SW_OFF/SW_ON the counter counts the wait. If the ack is not seen within ACK_TIMEOUT cycles of entry, go to ERR.
  - On entering ERR: err=1 and evt pulse.
  - err_clr in ERR: err=0, return to the timed-out state with the counter reloaded.
  - err_clr outside ERR is ignored.
- Ack arriving in the same cycle as the final timeout count: the ack wins.
- evt_o is registered, asserted the cycle the new state is visible on state_o.
- intr_o is registered from evt_o, so it lags evt_o by 1 cycle.
- Channels are fully independent; simultaneous events on several channels OR into one intr_o pulse.

Optional Feature:
Macro HEEPSILON_PWR_SEQ_RETENTION_EN.
- When defined: adds input ret_req_i[NUM_CH] and output ram_ret_o[NUM_CH] (reset 0).
  - If ret_req=1 when leaving RST, the channel goes to RET instead of SW_OFF.
  - RET tuple: (0,1,1,1), ram_ret=1; evt pulse on entry.
  - RET -> CLK_ON when off_req=0; ram_ret drops on exit.
  - No switch handshake and no timeout in RET.
- When undefined: no ports, no RET state, and ret behaviour is absent.

Decomposition:
- Package heepsilon_pwr_seq_pkg:
  - pwr_state_e, a 4-bit enum: ON=0, DRAIN=1, ISO=2, RST=3, SW_OFF=4, OFF=5, SW_ON=6, CLK_ON=7, DEISO=8, ERR=9, RET=10.
  - Default constants for ISO_SETTLE, RST_HOLD and ACK_TIMEOUT.
- Sub-module heepsilon_pwr_seq_ch: one channel FSM with its counter and ERR return register.
- Top level: generate loop over NUM_CH instances, plus the intr_o OR register.

Test Plan:
- Power-down, defaults, busy=0, ack falls 3 cycles after sw_on_o=0 -> sequence DRAIN(1) ISO(4) RST(8) SW_OFF(4) -> OFF; evt 1 pulse; intr 1 cycle later.
- busy=1 for 10 cycles, off_req dropped at cycle 5 -> DRAIN aborts to ON; no iso/rst toggle; no evt.
- OFF, off_req=0, ack rises after 2 cycles -> SW_ON, CLK_ON(8 cycles, ch_rst=1), DEISO(4), ON; on_o=1 and evt pulse on entry.
- ACK_TIMEOUT=16, ack never falls -> ERR at cycle 16 of SW_OFF with tuple (0,0,1,1) and err=1; err_clr then ack -> OFF.
- Ch0 and ch1 complete in the same cycle -> evt_o=2'b11, single intr pulse; rst_i asserted mid-RST -> ON, outputs at reset values next cycle.
- RETENTION_EN, ret_req=1 -> RST -> RET, ram_ret=1, sw_on stays 1; off_req=0 -> CLK_ON, ram_ret=0, then ON.

Source files
------------

// File: rtl/heepsilon_pwr_seq_pkg.sv
// Shared types and constants for the external-subsystem power sequencer.
// RET is only reachable when HEEPSILON_PWR_SEQ_RETENTION_EN is defined.
package heepsilon_pwr_seq_pkg;

  typedef enum logic [3:0] {
    ST_ON     = 4'd0,
    ST_DRAIN  = 4'd1,
    ST_ISO    = 4'd2,
    ST_RST    = 4'd3,
    ST_SW_OFF = 4'd4,
    ST_OFF    = 4'd5,
    ST_SW_ON  = 4'd6,
    ST_CLK_ON = 4'd7,
    ST_DEISO  = 4'd8,
    ST_ERR    = 4'd9,
    ST_RET    = 4'd10
  } pwr_state_e;

  localparam int unsigned ISO_SETTLE_DEF  = 4;
  localparam int unsigned RST_HOLD_DEF    = 8;
  localparam int unsigned ACK_TIMEOUT_DEF = 255;

  typedef struct packed {
    logic clk_en;
    logic sw_on;
    logic iso;
    logic ch_rst;
  } pwr_tuple_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // ERR is resolved by the caller to the state that timed out.
  function automatic pwr_tuple_t tuple_of(input pwr_state_e s);
    pwr_tuple_t t;
    t = '{clk_en: 1'b1, sw_on: 1'b1, iso: 1'b0, ch_rst: 1'b0};
    case (s)
      ST_ISO, ST_DEISO:    t = '{clk_en: 1'b1, sw_on: 1'b1, iso: 1'b1, ch_rst: 1'b0};
      ST_RST, ST_CLK_ON:   t = '{clk_en: 1'b1, sw_on: 1'b1, iso: 1'b1, ch_rst: 1'b1};
      ST_SW_OFF, ST_OFF:   t = '{clk_en: 1'b0, sw_on: 1'b0, iso: 1'b1, ch_rst: 1'b1};
      ST_SW_ON, ST_RET:    t = '{clk_en: 1'b0, sw_on: 1'b1, iso: 1'b1, ch_rst: 1'b1};
      default:             t = '{clk_en: 1'b1, sw_on: 1'b1, iso: 1'b0, ch_rst: 1'b0};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/heepsilon_ext_pwr_seq_if.sv
// Request/status bundle between the X-HEEP control side and the sequencer.
// Retention pins exist only with HEEPSILON_PWR_SEQ_RETENTION_EN defined.
interface heepsilon_ext_pwr_seq_if #(
  parameter int unsigned NUM_CH = 2
);
  logic [NUM_CH-1:0]   off_req_i;
  logic [NUM_CH-1:0]   busy_i;
  logic [NUM_CH-1:0]   sw_ack_i;
  logic [NUM_CH-1:0]   err_clr_i;
  logic [NUM_CH-1:0]   clk_en_o;
  logic [NUM_CH-1:0]   sw_on_o;
  logic [NUM_CH-1:0]   iso_o;
  logic [NUM_CH-1:0]   ch_rst_o;
  logic [4*NUM_CH-1:0] state_o;
  logic [NUM_CH-1:0]   on_o;
  logic [NUM_CH-1:0]   err_o;
  logic [NUM_CH-1:0]   evt_o;
  logic                intr_o;
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
  logic [NUM_CH-1:0]   ret_req_i;
  logic [NUM_CH-1:0]   ram_ret_o;

  modport master (output off_req_i, busy_i, sw_ack_i, err_clr_i, ret_req_i,
                  input  clk_en_o, sw_on_o, iso_o, ch_rst_o, state_o, on_o, err_o,
                         evt_o, intr_o, ram_ret_o);
  modport slave  (input  off_req_i, busy_i, sw_ack_i, err_clr_i, ret_req_i,
                  output clk_en_o, sw_on_o, iso_o, ch_rst_o, state_o, on_o, err_o,
                         evt_o, intr_o, ram_ret_o);
`else
  modport master (output off_req_i, busy_i, sw_ack_i, err_clr_i,
                  input  clk_en_o, sw_on_o, iso_o, ch_rst_o, state_o, on_o, err_o,
                         evt_o, intr_o);
  modport slave  (input  off_req_i, busy_i, sw_ack_i, err_clr_i,
                  output clk_en_o, sw_on_o, iso_o, ch_rst_o, state_o, on_o, err_o,
                         evt_o, intr_o);
`endif
endinterface

// File: rtl/heepsilon_pwr_seq_ch.sv
// One channel: drain/isolate/reset/clock/power sequencing FSM with dwell counter.
// HEEPSILON_PWR_SEQ_RETENTION_EN adds the RET (retention) branch out of RST.
module heepsilon_pwr_seq_ch
  import heepsilon_pwr_seq_pkg::*;
#(
  parameter int unsigned ISO_SETTLE  = ISO_SETTLE_DEF,
  parameter int unsigned RST_HOLD    = RST_HOLD_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       off_req_i,
  input  logic       busy_i,
  input  logic       sw_ack_i,
  input  logic       err_clr_i,
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
  input  logic       ret_req_i,
  output logic       ram_ret_o,
`endif
  output logic       clk_en_o,
  output logic       sw_on_o,
  output logic       iso_o,
  output logic       ch_rst_o,
  output logic [3:0] state_o,
  output logic       on_o,
  output logic       err_o,
  output logic       evt_o
);
  localparam int unsigned CNT_W = cnt_width(ISO_SETTLE, RST_HOLD, ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_SETTLE - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(ACK_TIMEOUT - 1);

  pwr_state_e       state_q, state_d;
  pwr_state_e       err_src_q, err_src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             cnt_zero;
  pwr_tuple_t       tup;

  assign cnt_zero = (cnt_q == '0);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_ON;
      err_src_q <= ST_ON;
      cnt_q     <= '0;
      evt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_src_q <= err_src_d;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
    end
  end

  // NOTE: defaults first so every path assigns every signal (no latches).
  always_comb begin
    state_d   = state_q;
    err_src_d = err_src_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    case (state_q)
      ST_ON:    if (off_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!off_req_i) begin
          state_d = ST_ON;
        end else if (!busy_i) begin
          state_d = ST_ISO;
          cnt_d   = ISO_LD;
        end
      end
      ST_ISO: if (cnt_zero) begin
        state_d = ST_RST;
        cnt_d   = RST_LD;
      end
      ST_RST: if (cnt_zero) begin
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
        state_d = ret_req_i ? ST_RET : ST_SW_OFF;
`else
        state_d = ST_SW_OFF;
`endif
        cnt_d   = ACK_LD;
      end
      // The ack is checked before the timeout so a last-cycle ack still wins.
      ST_SW_OFF: begin
        if (!sw_ack_i) begin
          state_d = ST_OFF;
        end else if (cnt_zero) begin
          state_d   = ST_ERR;
          err_src_d = ST_SW_OFF;
        end
      end
      ST_OFF: if (!off_req_i) begin
        state_d = ST_SW_ON;
        cnt_d   = ACK_LD;
      end
      ST_SW_ON: begin
        if (sw_ack_i) begin
          state_d = ST_CLK_ON;
          cnt_d   = RST_LD;
        end else if (cnt_zero) begin
          state_d   = ST_ERR;
          err_src_d = ST_SW_ON;
        end
      end
      ST_CLK_ON: if (cnt_zero) begin
        state_d = ST_DEISO;
        cnt_d   = ISO_LD;
      end
      ST_DEISO: if (cnt_zero) state_d = ST_ON;
      ST_ERR: if (err_clr_i) begin
        state_d = err_src_q;
        cnt_d   = ACK_LD;
      end
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
      ST_RET: if (!off_req_i) begin
        state_d = ST_CLK_ON;
        cnt_d   = RST_LD;
      end
`endif
      default: state_d = ST_ON;
    endcase

    // A DRAIN abort back to ON is not a completion, so it raises no event.
    evt_d = (state_d != state_q) &&
            ((state_d inside {ST_OFF, ST_ERR, ST_RET}) ||
             (state_d == ST_ON && state_q == ST_DEISO));
  end

  assign tup      = tuple_of((state_q == ST_ERR) ? err_src_q : state_q);
  assign clk_en_o = tup.clk_en;
  assign sw_on_o  = tup.sw_on;
  assign iso_o    = tup.iso;
  assign ch_rst_o = tup.ch_rst;
  assign state_o  = state_q;
  assign on_o     = (state_q == ST_ON);
  assign err_o    = (state_q == ST_ERR);
  assign evt_o    = evt_q;
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
  assign ram_ret_o = (state_q == ST_RET);
`endif

endmodule

// File: rtl/heepsilon_ext_pwr_seq.sv
// Power/clock/reset sequencer for NUM_CH external subsystems plus one OR'ed interrupt.
// Define HEEPSILON_PWR_SEQ_RETENTION_EN to enable the RAM-retention path.
module heepsilon_ext_pwr_seq
  import heepsilon_pwr_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ISO_SETTLE  = ISO_SETTLE_DEF,
  parameter int unsigned RST_HOLD    = RST_HOLD_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  heepsilon_ext_pwr_seq_if.slave  bus
);
  logic [NUM_CH-1:0]   clk_en, sw_on, iso, ch_rst, on, err, evt;
  logic [4*NUM_CH-1:0] state;
  logic                intr_q, intr_d;
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
  logic [NUM_CH-1:0]   ram_ret;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    heepsilon_pwr_seq_ch #(
      .ISO_SETTLE  (ISO_SETTLE),
      .RST_HOLD    (RST_HOLD),
      .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .off_req_i (bus.off_req_i[i]),
      .busy_i    (bus.busy_i[i]),
      .sw_ack_i  (bus.sw_ack_i[i]),
      .err_clr_i (bus.err_clr_i[i]),
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
      .ret_req_i (bus.ret_req_i[i]),
      .ram_ret_o (ram_ret[i]),
`endif
      .clk_en_o  (clk_en[i]),
      .sw_on_o   (sw_on[i]),
      .iso_o     (iso[i]),
      .ch_rst_o  (ch_rst[i]),
      .state_o   (state[4*i +: 4]),
      .on_o      (on[i]),
      .err_o     (err[i]),
      .evt_o     (evt[i])
    );
  end

  assign intr_d = |evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) intr_q <= 1'b0;
    else       intr_q <= intr_d;
  end

  assign bus.clk_en_o = clk_en;
  assign bus.sw_on_o  = sw_on;
  assign bus.iso_o    = iso;
  assign bus.ch_rst_o = ch_rst;
  assign bus.state_o  = state;
  assign bus.on_o     = on;
  assign bus.err_o    = err;
  assign bus.evt_o    = evt;
  assign bus.intr_o   = intr_q;
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
  assign bus.ram_ret_o = ram_ret;
`endif

endmodule

// File: tb/tb_heepsilon_ext_pwr_seq.sv
// Self-checking bench: run-length table of per-cycle inputs and expected channel states.
// Exercises the RET path too when HEEPSILON_PWR_SEQ_RETENTION_EN is defined.
module tb_heepsilon_ext_pwr_seq;
  import heepsilon_pwr_seq_pkg::*;

  localparam int unsigned NCH = 2;

  typedef struct {
    logic       rst;
    logic [1:0] off_req;
    logic [1:0] busy;
    logic [1:0] ack;
    logic [1:0] clr;
    logic [1:0] ret;
    int         n;
    pwr_state_e st0;
    pwr_state_e st1;
    logic [1:0] evt;
  } vec_t;

  typedef struct {
    pwr_state_e st0;
    pwr_state_e st1;
    logic [1:0] evt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vec_t vecs[$];
  exp_t sb[$];

  heepsilon_ext_pwr_seq_if #(.NUM_CH(NCH)) bus ();

  heepsilon_ext_pwr_seq #(
    .NUM_CH      (NCH),
    .ISO_SETTLE  (4),
    .RST_HOLD    (8),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] off, input logic [1:0] bsy,
                     input logic [1:0] ack, input logic [1:0] clr, input logic [1:0] ret,
                     input int n, input pwr_state_e s0, input pwr_state_e s1,
                     input logic [1:0] evt);
    vec_t v;
    v.rst = r; v.off_req = off; v.busy = bsy; v.ack = ack; v.clr = clr; v.ret = ret;
    v.n = n; v.st0 = s0; v.st1 = s1; v.evt = evt;
    vecs.push_back(v);
  endtask

  // Output tuple (clk_en, sw_on, iso, ch_rst) as listed for each state.
  function automatic logic [3:0] spec_tuple(input pwr_state_e s);
    case (s)
      ST_ON, ST_DRAIN:     return 4'b1100;
      ST_ISO, ST_DEISO:    return 4'b1110;
      ST_RST, ST_CLK_ON:   return 4'b1111;
      ST_SW_OFF, ST_OFF:   return 4'b0011;
      ST_SW_ON, ST_RET:    return 4'b0111;
      default:             return 4'bxxxx;
    endcase
  endfunction

  initial begin
    pwr_state_e last_ok[NCH];
    logic [1:0] prev_evt;
    exp_t       e;
    pwr_state_e st;
    logic [3:0] t;
    logic [NCH-1:0] x_clk, x_sw, x_iso, x_rst, x_on, x_err, x_ret;

    bus.off_req_i = '0; bus.busy_i = '0; bus.sw_ack_i = '1; bus.err_clr_i = '0;
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
    bus.ret_req_i = '0;
`endif
    for (int c = 0; c < NCH; c++) last_ok[c] = ST_ON;
    prev_evt = 2'b00;

    // rst off_req busy ack clr ret  n  ch0        ch1       evt
    add(1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2, ST_ON,     ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 1, ST_ON,     ST_ON,    2'b00);
    // power-down, ack falls after the 4th SW_OFF cycle
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_DRAIN,  ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_ISO,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 8, ST_RST,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_SW_OFF, ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 1, ST_OFF,    ST_ON,    2'b01);
    add(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 3, ST_OFF,    ST_ON,    2'b00);
    // power-up, ack rises after 2 SW_ON cycles
    add(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2, ST_SW_ON,  ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 8, ST_CLK_ON, ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_DEISO,  ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b01);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2, ST_ON,     ST_ON,    2'b00);
    // drain abort: busy held, request withdrawn
    add(0, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 5, ST_DRAIN,  ST_ON,    2'b00);
    add(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 5, ST_ON,     ST_ON,    2'b00);
    // SW_OFF timeout, error clear, then ack
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_DRAIN,  ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_ISO,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 8, ST_RST,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00,16, ST_SW_OFF, ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ERR,    ST_ON,    2'b01);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2, ST_ERR,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 1, ST_SW_OFF, ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 1, ST_OFF,    ST_ON,    2'b01);
    add(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2, ST_OFF,    ST_ON,    2'b00);
    // SW_ON: ack arrives together with the final timeout count
    add(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,16, ST_SW_ON,  ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 8, ST_CLK_ON, ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_DEISO,  ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b01);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b00);
    // both channels in lockstep: one shared event cycle
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_DRAIN,  ST_DRAIN, 2'b00);
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_ISO,    ST_ISO,   2'b00);
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 8, ST_RST,    ST_RST,   2'b00);
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_SW_OFF, ST_SW_OFF,2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, ST_OFF,    ST_OFF,   2'b11);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2, ST_OFF,    ST_OFF,   2'b00);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, ST_SW_ON,  ST_SW_ON, 2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 8, ST_CLK_ON, ST_CLK_ON,2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_DEISO,  ST_DEISO, 2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b11);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b00);
    // reset in the middle of RST
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_DRAIN,  ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_ISO,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 3, ST_RST,    ST_ON,    2'b00);
    add(1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2, ST_ON,     ST_ON,    2'b00);
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
    // retention: RST -> RET -> CLK_ON, switch never opened
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 1, ST_DRAIN,  ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 4, ST_ISO,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 8, ST_RST,    ST_ON,    2'b00);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 1, ST_RET,    ST_ON,    2'b01);
    add(0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2, ST_RET,    ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 8, ST_CLK_ON, ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4, ST_DEISO,  ST_ON,    2'b00);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b01);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, ST_ON,     ST_ON,    2'b00);
`endif

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        @(negedge clk);
        rst           = vecs[v].rst;
        bus.off_req_i = vecs[v].off_req;
        bus.busy_i    = vecs[v].busy;
        bus.sw_ack_i  = vecs[v].ack;
        bus.err_clr_i = vecs[v].clr;
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
        bus.ret_req_i = vecs[v].ret;
`endif
        e.st0 = vecs[v].st0;
        e.st1 = vecs[v].st1;
        e.evt = (k == 0) ? vecs[v].evt : 2'b00;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard @%0t: empty queue", $time);
        end else begin
          e = sb.pop_front();
          for (int c = 0; c < NCH; c++) begin
            st = (c == 0) ? e.st0 : e.st1;
            t  = spec_tuple((st == ST_ERR) ? last_ok[c] : st);
            if (st != ST_ERR) last_ok[c] = st;
            {x_clk[c], x_sw[c], x_iso[c], x_rst[c]} = t;
            x_on[c]  = (st == ST_ON);
            x_err[c] = (st == ST_ERR);
            x_ret[c] = (st == ST_RET);
            check($sformatf("v%0d.%0d state ch%0d", v, k, c),
                  32'(bus.state_o[4*c +: 4]), 32'(st));
          end
          check($sformatf("v%0d.%0d clk_en", v, k), 32'(bus.clk_en_o), 32'(x_clk));
          check($sformatf("v%0d.%0d sw_on", v, k),  32'(bus.sw_on_o),  32'(x_sw));
          check($sformatf("v%0d.%0d iso", v, k),    32'(bus.iso_o),    32'(x_iso));
          check($sformatf("v%0d.%0d ch_rst", v, k), 32'(bus.ch_rst_o), 32'(x_rst));
          check($sformatf("v%0d.%0d on", v, k),     32'(bus.on_o),     32'(x_on));
          check($sformatf("v%0d.%0d err", v, k),    32'(bus.err_o),    32'(x_err));
          check($sformatf("v%0d.%0d evt", v, k),    32'(bus.evt_o),    32'(e.evt));
          check($sformatf("v%0d.%0d intr", v, k),   32'(bus.intr_o),   32'(|prev_evt));
`ifdef HEEPSILON_PWR_SEQ_RETENTION_EN
          check($sformatf("v%0d.%0d ram_ret", v, k), 32'(bus.ram_ret_o), 32'(x_ret));
`endif
          prev_evt = e.evt;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
